// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   InstAddrBus / InstBus : address and instruction widths
//   rst_enable            : active level of the synchronous reset
//   fetch_state_e         : FSM state encodings
//   CACHE_IDX_W_DEF       : default log2 of instruction-cache entries
package inst_fetch_pkg;

  localparam int   InstAddrBus     = 32;
  localparam int   InstBus         = 32;
  localparam logic rst_enable      = 1'b1;
  localparam int   CACHE_IDX_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Fetch addresses are word aligned; the two low PC bits carry no meaning.
  function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] pc);
    return pc & ~(InstAddrBus'(3));
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit instruction per line.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears valid bits)
//   rd_idx, rd_tag    : lookup index/tag (combinational read)
//   hit, rd_data      : lookup result
//   wr_en, wr_idx,
//   wr_tag, wr_data   : synchronous line fill
// A write and a read of the same index in one cycle returns the old line.
module icache_dm
  import inst_fetch_pkg::*;
#(
  parameter int CACHE_IDX_W = CACHE_IDX_W_DEF,
  localparam int TAG_W      = InstAddrBus - CACHE_IDX_W - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CACHE_IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0]       rd_tag,
  output logic                   hit,
  output logic [InstBus-1:0]     rd_data,
  input  logic                   wr_en,
  input  logic [CACHE_IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic [InstBus-1:0]     wr_data
);

  localparam int ENTRIES = 1 << CACHE_IDX_W;

  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [InstBus-1:0] data_mem [ENTRIES];
  logic [ENTRIES-1:0] valid_bits;

  always_ff @(posedge clk) begin
    if (rst == rst_enable) begin
      valid_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid_bits[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: cache lookup, byte-wise miss fill, decode handoff.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   pc_in, pc_valid       : fetch address and its qualifier from the PC register
//   jump_flush            : execute redirect, aborts anything in flight
//   id_stall              : decode cannot accept; outputs hold
//   stall_req             : freezes the PC register while a miss is filling
//   mem_req, mem_addr     : byte read request to the memory controller
//   mem_ready, mem_byte   : one-cycle byte return
//   inst_valid, inst_out,
//   inst_pc               : instruction handed to decode
//
// state   | meaning
// IDLE    | accept a PC; hits are returned next cycle
// MISS    | fetch four bytes of the latched PC, lane cnt at a time
// HOLD    | present the filled word; leave once decode is not stalled
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int CACHE_IDX_W = CACHE_IDX_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] pc_in,
  input  logic                   pc_valid,
  input  logic                   jump_flush,
  input  logic                   id_stall,
  output logic                   stall_req,
  output logic                   mem_req,
  output logic [InstAddrBus-1:0] mem_addr,
  input  logic                   mem_ready,
  input  logic [7:0]             mem_byte,
  output logic                   inst_valid,
  output logic [InstBus-1:0]     inst_out,
  output logic [InstAddrBus-1:0] inst_pc
);

  localparam int TAG_W = InstAddrBus - CACHE_IDX_W - 2;

  fetch_state_e           state, state_nxt;
  logic [1:0]             cnt;
  logic [InstAddrBus-1:0] pc_lat;
  logic [InstBus-1:0]     asm_word;
  logic [InstBus-1:0]     fill_word;
  logic                   cache_hit;
  logic [InstBus-1:0]     cache_data;
  logic                   cache_we;

  logic load_hit, start_miss, take_byte, load_fill, load_asm, clr_valid;

  icache_dm #(.CACHE_IDX_W(CACHE_IDX_W)) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc_in[CACHE_IDX_W+1:2]),
    .rd_tag  (pc_in[InstAddrBus-1:CACHE_IDX_W+2]),
    .hit     (cache_hit),
    .rd_data (cache_data),
    .wr_en   (cache_we),
    .wr_idx  (pc_lat[CACHE_IDX_W+1:2]),
    .wr_tag  (pc_lat[InstAddrBus-1:CACHE_IDX_W+2]),
    .wr_data (fill_word)
  );

  // The last byte goes straight into the cache line and the output together.
  assign fill_word = {mem_byte, asm_word[23:0]};

  always_ff @(posedge clk) begin
    if (rst == rst_enable) state <= ST_IDLE;
    else                   state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_hit   = 1'b0;
    start_miss = 1'b0;
    take_byte  = 1'b0;
    load_fill  = 1'b0;
    load_asm   = 1'b0;
    clr_valid  = 1'b0;
    stall_req  = (state == ST_MISS);
    mem_req    = (state == ST_MISS);
    mem_addr   = (state == ST_MISS) ? pc_lat + {30'b0, cnt} : '0;

    if (jump_flush) begin
      state_nxt = ST_IDLE;
      clr_valid = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!id_stall) begin
            if (pc_valid && cache_hit) begin
              load_hit = 1'b1;
            end else begin
              clr_valid = 1'b1;
              if (pc_valid) begin
                start_miss = 1'b1;
                state_nxt  = ST_MISS;
              end
            end
          end
        end
        ST_MISS: begin
          if (mem_ready) begin
            take_byte = 1'b1;
            if (cnt == 2'd3) begin
              state_nxt = ST_HOLD;
              load_fill = !id_stall;
            end
          end
        end
        ST_HOLD: begin
          // inst_valid is low throughout MISS, so a low value here means the
          // fill completed under a decode stall and has not been shown yet.
          if (!id_stall) begin
            if (inst_valid) begin
              clr_valid = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              load_asm = 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign cache_we = take_byte && (cnt == 2'd3) && (rst != rst_enable);

  always_ff @(posedge clk) begin
    if (rst == rst_enable) begin
      cnt        <= '0;
      pc_lat     <= '0;
      asm_word   <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
    end else begin
      if (start_miss) begin
        pc_lat <= align_pc(pc_in);
        cnt    <= '0;
      end
      if (take_byte) begin
        asm_word[{cnt, 3'b000} +: 8] <= mem_byte;
        cnt                          <= cnt + 2'd1;
      end
      if (load_hit) begin
        inst_valid <= 1'b1;
        inst_out   <= cache_data;
        inst_pc    <= align_pc(pc_in);
      end else if (load_fill) begin
        inst_valid <= 1'b1;
        inst_out   <= fill_word;
        inst_pc    <= pc_lat;
      end else if (load_asm) begin
        inst_valid <= 1'b1;
        inst_out   <= asm_word;
        inst_pc    <= pc_lat;
      end else if (clr_valid) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        jump_flush;
  logic        id_stall;
  logic        stall_req;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_byte = 8'h00;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  int checks = 0;
  int failures = 0;

  logic [31:0] served[$];
  logic        req_prev = 1'b0;

  always #5 clk = ~clk;

  inst_fetch #(.CACHE_IDX_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .jump_flush (jump_flush),
    .id_stall   (id_stall),
    .stall_req  (stall_req),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_byte   (mem_byte),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc)
  );

  // Memory image: address 0..3 holds 13,00,00,00; elsewhere a hash of the address.
  function automatic logic [7:0] byte_at(input logic [31:0] a);
    if (a[31:2] == 30'd0) return (a[1:0] == 2'd0) ? 8'h13 : 8'h00;
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
  endfunction

  // Memory answers every cycle after the first cycle of a request burst.
  always @(negedge clk) begin
    if (mem_req && req_prev) begin
      mem_ready = 1'b1;
      mem_byte  = byte_at(mem_addr);
      served.push_back(mem_addr);
    end else begin
      mem_ready = 1'b0;
      mem_byte  = 8'h00;
    end
    req_prev = mem_req;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full miss starting at the current negedge; ends one cycle after the word appears.
  task automatic fetch_miss(input logic [31:0] pc);
    int cyc;
    int stalls;
    pc_valid = 1'b1;
    pc_in    = pc;
    served.delete();
    @(negedge clk);
    pc_valid = 1'b0;
    cyc      = 1;
    stalls   = 0;
    while (!inst_valid && cyc < 20) begin
      if (stall_req) stalls++;
      @(negedge clk);
      cyc++;
    end
    check("miss_latency", cyc, 6);
    check("miss_stall_cycles", stalls, 5);
    check("miss_stall_low_at_valid", stall_req, 1'b0);
    check("miss_word", inst_out, word_at(pc));
    check("miss_pc", inst_pc, pc);
    check("miss_req_count", served.size(), 4);
    for (int i = 0; i < 4 && i < served.size(); i++)
      check($sformatf("miss_addr%0d", i), served[i], pc + 32'(i));
    @(negedge clk);
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        stall;
    logic        jf;
    logic        e_valid;
    logic        e_sreq;
    logic        e_mreq;
    logic [31:0] e_out;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pc_valid = 1'b0; pc_in = '0; jump_flush = 1'b0; id_stall = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_stall_req", stall_req, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, then warm two more lines.
    fetch_miss(32'h0000_0000);
    check("cold_word_literal", inst_out, 32'h0000_0013);
    fetch_miss(32'h0000_0004);
    fetch_miss(32'h0000_0008);

    // pv pc stall jf | valid stall_req mem_req out pc
    vecs[0]  = '{1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0};
    vecs[1]  = '{1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, word_at(32'h4), 32'h4};
    vecs[2]  = '{1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, word_at(32'h8), 32'h8};
    vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, word_at(32'h8), 32'h8};
    vecs[4]  = '{1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, word_at(32'h4), 32'h4};
    vecs[5]  = '{1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, word_at(32'h4), 32'h4};
    vecs[6]  = '{1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, word_at(32'h4), 32'h4};
    vecs[7]  = '{1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, word_at(32'h4), 32'h4};
    vecs[8]  = '{1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, word_at(32'h8), 32'h8};
    vecs[9]  = '{1'b1, 32'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, word_at(32'h4), 32'h4};
    vecs[10] = '{1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, word_at(32'h4), 32'h4};
    vecs[11] = '{1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, word_at(32'h8), 32'h8};

    for (int i = 0; i < 12; i++) begin
      pc_valid   = vecs[i].pv;
      pc_in      = vecs[i].pc;
      id_stall   = vecs[i].stall;
      jump_flush = vecs[i].jf;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {inst_valid, stall_req, mem_req, inst_out, inst_pc},
            {vecs[i].e_valid, vecs[i].e_sreq, vecs[i].e_mreq, vecs[i].e_out, vecs[i].e_pc});
    end
    pc_valid = 1'b0; id_stall = 1'b0; jump_flush = 1'b0;
    @(negedge clk);

    // Flush after the second byte of a fetch at 0x100.
    pc_valid = 1'b1; pc_in = 32'h100;
    @(negedge clk);
    pc_valid = 1'b0;
    check("flush_pre_stall_req", stall_req, 1'b1);
    repeat (3) @(negedge clk);
    jump_flush = 1'b1;
    @(negedge clk);
    jump_flush = 1'b0;
    check("flush_mem_req", mem_req, 1'b0);
    check("flush_stall_req", stall_req, 1'b0);
    check("flush_inst_valid", inst_valid, 1'b0);
    @(negedge clk);
    fetch_miss(32'h100);

    // 0x000 shares the index with 0x100, so it has been evicted.
    fetch_miss(32'h000);

    // Decode stall spanning the end of a miss: HOLD waits for decode.
    pc_valid = 1'b1; pc_in = 32'h40;
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    id_stall = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_stalled_a", {inst_valid, stall_req, mem_req}, 3'b000);
    @(negedge clk);
    check("hold_stalled_b", {inst_valid, stall_req, mem_req}, 3'b000);
    id_stall = 1'b0;
    @(negedge clk);
    check("hold_release", {inst_valid, inst_out, inst_pc}, {1'b1, word_at(32'h40), 32'h40});
    @(negedge clk);
    check("hold_consumed", inst_valid, 1'b0);

    // Top of the address space: bytes FFFC..FFFF, no wrap.
    fetch_miss(32'hFFFF_FFFC);

    // Reset after the third byte of a fetch at 0x200.
    pc_valid = 1'b1; pc_in = 32'h200;
    @(negedge clk);
    pc_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmiss_outputs",
          {inst_valid, stall_req, mem_req, mem_addr, inst_out, inst_pc}, '0);
    rst = 1'b0;
    @(negedge clk);
    fetch_miss(32'h200);
    fetch_miss(32'h004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
